spi_slave_reg_ctrl: RTL and testbench

- Sequences SPI slave transactions (mode 0, MSB first) against a 4 x 8-bit register file, entirely in the system `clk` domain.
- SCLK, SS and MOSI are oversampled through synchronisers.
- First byte of each SS-low frame is a command (R/W + address); following bytes are burst data.
- A local write port shares the register file with the SPI side; SPI wins on collision. Sits between the board SPI pins and the on-chip register consumers.

---
 rtl/spi_slave_reg_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_reg_ctrl.sv
`timescale 1ns/1ps
// Purpose: SPI mode-0 slave that fronts a 4 x 8-bit register file, running entirely on clk.
// Latency: an SPI register write lands on reg_q SYNC_STAGES+1 clk after the 8th SCLK pin rise.
// Backpressure: none; the SPI master and the local port are never stalled. A colliding local write is dropped.
//
// Ports:
//   clk, rst               system clock (>= 8x SCLK), asynchronous active-high reset
//   SCLK, SS, MOSI         SPI pins from the master, asynchronous to clk
//   MISO                   slave data out, high-impedance while SS (synchronised) is high
//   lcl_we/addr/wdata      local register write port; loses to an SPI write to the same register
//   reg_q                  register contents, reg[n] at bits [8n+7:8n]
//   done                   one-cycle pulse per completed SPI data byte
//   lcl_drop               one-cycle pulse when a local write was discarded by collision
//   busy                   high while a frame is being sequenced
//
// Build option: define SPI_ADDR_AUTOINC_EN to post-increment the address (mod 4) after every
// data byte; without it the address stays fixed for the whole frame.
//
// Frame format: byte 0 is a command, bit 7 = 1 for write / 0 for read, bits [1:0] = address,
// bits [6:2] ignored. Every following byte is burst data.

module spi_slave_reg_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        lcl_we,
  input  logic [1:0]  lcl_addr,
  input  logic [7:0]  lcl_wdata,
  output logic [31:0] reg_q,
  output logic        done,
  output logic        lcl_drop,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t state;

  // Synchroniser chains; the top bit of each chain is the usable synchronised signal.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sclk_d;
  logic ss_d;

  logic rise;
  logic fall;
  logic ss_fall;

  logic [2:0]      bit_cnt;
  logic [1:0]      addr;
  logic [1:0]      addr_nxt;
  // Only the seven older bits are kept; the eighth bit is MOSI itself on the completing rise.
  logic [6:0]      rx_sh;
  logic [7:0]      tx_sh;
  logic [7:0]      rx_byte;
  logic            byte_done;
  logic            spi_wr;
  logic            lcl_hit;
  logic [3:0][7:0] regs;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  // SS resets to the deasserted level so the slave starts idle with MISO released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];

  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign ss_fall = ss_d & ~ss_s;

  // ---------------------------------------------------------------------------
  // Byte assembly helpers
  // ---------------------------------------------------------------------------
  assign rx_byte   = {rx_sh, mosi_s};
  assign byte_done = rise && !ss_s && (bit_cnt == 3'd7) && (state != IDLE);
  assign spi_wr    = (state == WDATA) && byte_done;
  assign lcl_hit   = lcl_we && spi_wr && (lcl_addr == addr);

`ifdef SPI_ADDR_AUTOINC_EN
  assign addr_nxt = addr + 2'd1;
`else
  assign addr_nxt = addr;
`endif

  // ---------------------------------------------------------------------------
  // Register file: the local write is applied first so an SPI write to the
  // same register in the same cycle overrides it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= {4{RST_VAL}};
    end else begin
      if (lcl_we && !lcl_hit) begin
        regs[lcl_addr] <= lcl_wdata;
      end
      if (spi_wr) begin
        regs[addr] <= rx_byte;
      end
    end
  end

  assign reg_q = regs;

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      addr     <= 2'd0;
      rx_sh    <= 7'd0;
      tx_sh    <= 8'd0;
      done     <= 1'b0;
      lcl_drop <= 1'b0;
    end else begin
      done     <= 1'b0;
      lcl_drop <= lcl_hit;

      if (ss_s) begin
        // Deselect abandons whatever partial byte was in flight.
        state   <= IDLE;
        bit_cnt <= 3'd0;
      end else begin
        if (state != IDLE) begin
          if (rise) begin
            rx_sh   <= {rx_sh[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
          end
          // The first fall after a byte boundary must not shift, otherwise the
          // freshly loaded MSB would be lost before the master samples it.
          if (fall && (bit_cnt != 3'd0)) begin
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end

        case (state)
          IDLE: begin
            if (ss_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
            end
          end
          CMD: begin
            if (byte_done) begin
              addr <= rx_byte[1:0];
              if (rx_byte[7]) begin
                state <= WDATA;
              end else begin
                state <= RDATA;
                tx_sh <= regs[rx_byte[1:0]];
              end
            end
          end
          WDATA: begin
            if (byte_done) begin
              done <= 1'b1;
              addr <= addr_nxt;
            end
          end
          RDATA: begin
            // Reloading every byte picks up local updates made since the last load,
            // while the byte currently on the wire stays a stable snapshot.
            if (byte_done) begin
              done  <= 1'b1;
              addr  <= addr_nxt;
              tx_sh <= regs[addr_nxt];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);
  assign MISO = ss_s ? 1'bz : ((state == RDATA) ? tx_sh[7] : 1'b0);

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave_reg_ctrl: directed frames from the test plan plus
// randomised frames, each compared against a byte-level model of the register file.

module tb_spi_slave_reg_ctrl;

  localparam int         SYNC = 2;
  localparam logic [7:0] RV   = 8'h00;

`ifdef SPI_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK;
  logic        SS;
  logic        MOSI;
  wire         MISO;
  logic        lcl_we;
  logic [1:0]  lcl_addr;
  logic [7:0]  lcl_wdata;
  logic [31:0] reg_q;
  logic        done;
  logic        lcl_drop;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  logic [7:0]  model  [4];
  logic [7:0]  tx_b   [8];
  logic [7:0]  rx_b   [8];
  logic [7:0]  exp_rx [8];
  logic [31:0] early_q;
  logic [31:0] late_q;

  spi_slave_reg_ctrl #(
    .SYNC_STAGES (SYNC),
    .RST_VAL     (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .SS        (SS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .lcl_we    (lcl_we),
    .lcl_addr  (lcl_addr),
    .lcl_wdata (lcl_wdata),
    .reg_q     (reg_q),
    .done      (done),
    .lcl_drop  (lcl_drop),
    .busy      (busy)
  );

  // clk posedges at x5 ns; all stimulus and sampling happens at x0 ns.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (lcl_drop) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_q();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Frame-level model: command byte selects direction and start address, then
  // each data byte writes or reads one register, address stepping if enabled.
  task automatic model_frame(input int nb, output int ndone, output int last_wa);
    int a;
    a       = int'(tx_b[0][1:0]);
    ndone   = 0;
    last_wa = -1;
    exp_rx[0] = 8'h00;
    for (int k = 1; k < nb; k++) begin
      if (tx_b[0][7]) begin
        model[a] = tx_b[k];
        last_wa  = a;
      end else begin
        exp_rx[k] = model[a];
      end
      ndone++;
      if (AUTOINC) a = (a + 1) % 4;
    end
  endtask

  task automatic lcl_write(input logic [1:0] a, input logic [7:0] d);
    lcl_addr  = a;
    lcl_wdata = d;
    lcl_we    = 1'b1;
    #10;
    lcl_we    = 1'b0;
    model[a]  = d;
    #10;
  endtask

  // Drives nb whole bytes from tx_b plus 'tail' leading bits of tx_b[nb], MSB first,
  // mode 0, 100 ns SCLK. On the last whole bit it samples reg_q just before and just
  // after the expected commit edge and optionally fires a local write on that edge.
  task automatic spi_frame(input int nb, input int tail, input bit lw_en,
                           input logic [1:0] la, input logic [7:0] ld);
    int nbits;
    SS = 1'b0;
    #100;
    for (int b = 0; b < nb + ((tail > 0) ? 1 : 0); b++) begin
      nbits = (b == nb) ? tail : 8;
      for (int i = 7; i > 7 - nbits; i--) begin
        MOSI = tx_b[b][i];
        #50;
        SCLK = 1'b1;
        rx_b[b][i] = MISO;
        if (b == nb - 1 && i == 0) begin
          #(10 * SYNC);
          early_q = reg_q;
          if (lw_en) begin
            lcl_addr  = la;
            lcl_wdata = ld;
            lcl_we    = 1'b1;
          end
          #10;
          late_q = reg_q;
          lcl_we = 1'b0;
          #(40 - 10 * SYNC);
        end else begin
          #50;
        end
        SCLK = 1'b0;
      end
    end
    #50;
    SS   = 1'b1;
    MOSI = 1'b0;
    #100;
  endtask

  task automatic run_frame(input string tag, input int nb, input bit lw_en,
                           input logic [1:0] la, input logic [7:0] ld);
    int d0, p0, nd, lwa;
    d0 = done_cnt;
    p0 = drop_cnt;
    spi_frame(nb, 0, lw_en, la, ld);
    if (lw_en) model[la] = ld;
    model_frame(nb, nd, lwa);
    chk({tag, "_regs"}, reg_q, model_q());
    chk({tag, "_done"}, done_cnt - d0, nd);
    chk({tag, "_drop"}, drop_cnt - p0, (lw_en && lwa == int'(la) && lwa >= 0) ? 1 : 0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (!tx_b[0][7]) begin
      for (int k = 0; k < nb; k++) begin
        chk($sformatf("%s_rx%0d", tag, k), rx_b[k], exp_rx[k]);
      end
    end
  endtask

  initial begin
    int d0, nb;

    rst = 1'b1; SCLK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    lcl_we = 1'b0; lcl_addr = 2'd0; lcl_wdata = 8'd0;
    for (int i = 0; i < 4; i++) model[i] = RV;

    #10;
    chk("rst_regs", reg_q, {4{RV}});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_drop", {31'd0, lcl_drop}, 32'd0);
    #10;
    rst = 1'b0;
    #40;

    // Single write, with commit latency probe.
    tx_b[0] = 8'h81; tx_b[1] = 8'hA5;
    run_frame("wr1", 2, 1'b0, 2'd0, 8'd0);
    chk("wr1_reg1", reg_q[15:8], 8'hA5);
    chk("wr1_lat_early", early_q[15:8], 8'h00);
    chk("wr1_lat_late", late_q[15:8], 8'hA5);

    // Burst write starting at register 3.
    tx_b[0] = 8'h83; tx_b[1] = 8'h11; tx_b[2] = 8'h22;
    run_frame("wrb", 3, 1'b0, 2'd0, 8'd0);
`ifdef SPI_ADDR_AUTOINC_EN
    chk("wrb_reg3", reg_q[31:24], 8'h11);
    chk("wrb_reg0", reg_q[7:0], 8'h22);
`else
    chk("wrb_reg3", reg_q[31:24], 8'h22);
`endif

    // Burst read after local preload.
    lcl_write(2'd2, 8'h3C);
    lcl_write(2'd3, 8'hC3);
    chk("lcl_pre", reg_q[31:16], 16'hC33C);
    tx_b[0] = 8'h02; tx_b[1] = 8'h00; tx_b[2] = 8'hFF;
    run_frame("rdb", 3, 1'b0, 2'd0, 8'd0);
    chk("rdb_cmd_miso", rx_b[0], 8'h00);
    chk("rdb_b1", rx_b[1], 8'h3C);
`ifdef SPI_ADDR_AUTOINC_EN
    chk("rdb_b2", rx_b[2], 8'hC3);
`else
    chk("rdb_b2", rx_b[2], 8'h3C);
`endif

    // Abort after five data bits, then a clean frame to the same register.
    tx_b[0] = 8'h80; tx_b[1] = 8'h5D;
    d0 = done_cnt;
    spi_frame(1, 5, 1'b0, 2'd0, 8'd0);
    chk("abort_regs", reg_q, model_q());
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tx_b[0] = 8'h80; tx_b[1] = 8'h7E;
    run_frame("post_abort", 2, 1'b0, 2'd0, 8'd0);
    chk("post_abort_reg0", reg_q[7:0], 8'h7E);

    // Collision on the same register, then on a different one.
    tx_b[0] = 8'h81; tx_b[1] = 8'h5A;
    run_frame("coll_same", 2, 1'b1, 2'd1, 8'hFF);
    chk("coll_same_reg1", reg_q[15:8], 8'h5A);
    tx_b[0] = 8'h81; tx_b[1] = 8'h5A;
    run_frame("coll_diff", 2, 1'b1, 2'd2, 8'hFF);
    chk("coll_diff_reg2", reg_q[23:16], 8'hFF);
    chk("coll_diff_reg1", reg_q[15:8], 8'h5A);

    // Randomised frames interleaved with local writes.
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 1) == 1) lcl_write(2'($urandom_range(0, 3)), 8'($urandom));
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) tx_b[k] = 8'($urandom);
      run_frame($sformatf("rnd%0d", r), nb, 1'b0, 2'd0, 8'd0);
    end

    // Asynchronous reset in the middle of a frame.
    SS = 1'b0;
    #100;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1; #50; SCLK = 1'b1; #50; SCLK = 1'b0;
    end
    #3;
    rst = 1'b1;
    #2;
    chk("arst_regs", reg_q, {4{RV}});
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_drop", {31'd0, lcl_drop}, 32'd0);
    #15;
    SS = 1'b1;
    rst = 1'b0;
    #50;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
